// File: rtl/light_bar_driver.sv
// light_bar_driver: bicolour lamp-bar output stage with green/red die multiplexing and PWM dimming.
// Optional: define LIGHT_BAR_GAMMA_EN to load the duty latch through a perceptual table (BRIGHT_W=4 only).
module light_bar_driver #(
    parameter int PRESCALE = 64,
    parameter int BRIGHT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          green_in,
    input  logic [7:0]          red_in,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [7:0]          led_green,
    output logic [7:0]          led_red,
    output logic                frame_start
);
    localparam int PRESC_W = $clog2(PRESCALE);
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(PRESCALE - 1);
    localparam logic [BRIGHT_W-1:0] PWM_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        PHASE_G,
        PHASE_R
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PRESC_W-1:0]  presc;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [BRIGHT_W-1:0] duty_lat;
    logic [BRIGHT_W-1:0] duty_code;
    logic [7:0]          g_lat;
    logic [7:0]          r_lat;
    logic                tick;
    logic                phase_end;
    logic                latch_now;
    logic [7:0]          green_drive;
    logic [7:0]          red_drive;

    assign tick      = (presc == PRESC_MAX);
    assign phase_end = tick && (pwm_cnt == PWM_MAX);

`ifdef LIGHT_BAR_GAMMA_EN
    if (BRIGHT_W != 4) begin : gen_gamma_width_check
        $error("LIGHT_BAR_GAMMA_EN requires BRIGHT_W == 4");
    end

    always_comb begin
        duty_code = '0;
        case (brightness)
            4'd0:    duty_code = 4'd0;
            4'd1:    duty_code = 4'd1;
            4'd2:    duty_code = 4'd1;
            4'd3:    duty_code = 4'd2;
            4'd4:    duty_code = 4'd2;
            4'd5:    duty_code = 4'd3;
            4'd6:    duty_code = 4'd3;
            4'd7:    duty_code = 4'd4;
            4'd8:    duty_code = 4'd5;
            4'd9:    duty_code = 4'd6;
            4'd10:   duty_code = 4'd7;
            4'd11:   duty_code = 4'd8;
            4'd12:   duty_code = 4'd10;
            4'd13:   duty_code = 4'd11;
            4'd14:   duty_code = 4'd13;
            default: duty_code = 4'd15;
        endcase
    end
`else
    assign duty_code = brightness;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping enable always wins, whatever phase the frame is in.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = PHASE_G;
                PHASE_G: if (phase_end) next_state = PHASE_R;
                PHASE_R: if (phase_end) next_state = PHASE_G;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        latch_now   = 1'b0;
        green_drive = '0;
        red_drive   = '0;
        case (state)
            IDLE:    latch_now = enable;
            PHASE_G: green_drive = (pwm_cnt < duty_lat) ? g_lat : 8'h00;
            PHASE_R: begin
                red_drive = (pwm_cnt < duty_lat) ? r_lat : 8'h00;
                latch_now = enable && phase_end;
            end
            default: ;
        endcase
    end

    // Inputs are only sampled on frame boundaries so a pattern never tears mid-frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            g_lat       <= '0;
            r_lat       <= '0;
            duty_lat    <= '0;
            led_green   <= '0;
            led_red     <= '0;
            frame_start <= 1'b0;
        end else begin
            led_green   <= green_drive;
            led_red     <= red_drive;
            frame_start <= latch_now;
            if (latch_now) begin
                g_lat    <= green_in;
                r_lat    <= red_in;
                duty_lat <= duty_code;
            end
            if (!enable || state == IDLE) begin
                presc   <= '0;
                pwm_cnt <= '0;
            end else if (tick) begin
                presc   <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                presc   <= presc + 1'b1;
            end
        end
    end

    die_exclusive: assert property (@(posedge clock) disable iff (!reset) (led_green & led_red) == 8'h00);

endmodule

// File: tb/tb_light_bar_driver.sv
// tb_light_bar_driver: table-driven frame checks plus directed tearing, enable-drop and reset sequences.
module tb_light_bar_driver;
    localparam int PRESCALE = 2;
    localparam int BRIGHT_W = 4;
    localparam int FRAME    = 2 * (2 ** BRIGHT_W) * PRESCALE;

    logic                clock;
    logic                reset;
    logic                enable;
    logic [7:0]          green_in;
    logic [7:0]          red_in;
    logic [BRIGHT_W-1:0] brightness;
    logic [7:0]          led_green;
    logic [7:0]          led_red;
    logic                frame_start;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0]          g;
        logic [7:0]          r;
        logic [BRIGHT_W-1:0] b;
    } vec_t;

    vec_t vecs[6];

    light_bar_driver #(.PRESCALE(PRESCALE), .BRIGHT_W(BRIGHT_W)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .green_in(green_in),
        .red_in(red_in),
        .brightness(brightness),
        .led_green(led_green),
        .led_red(led_red),
        .frame_start(frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int exp_duty(input int b);
`ifdef LIGHT_BAR_GAMMA_EN
        int table_g[16] = '{0, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 8, 10, 11, 13, 15};
        return table_g[b];
`else
        return b;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Takes the bar through IDLE, presents a new pattern, and re-enables.
    task automatic applyStimulus(input logic [7:0] g, input logic [7:0] r, input logic [BRIGHT_W-1:0] b);
        enable = 1'b0;
        repeat (2) @(negedge clock);
        green_in   = g;
        red_in     = r;
        brightness = b;
        enable     = 1'b1;
    endtask

    task automatic waitFrameStart(input string name);
        int seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clock);
            if (frame_start) seen = 1;
        end
        checkOutput(name, seen, 1);
    endtask

    // Observes one full frame starting right after a frame_start sample.
    task automatic measureFrame(input string name, input logic [7:0] g_exp, input logic [7:0] r_exp,
                                input int g_on_exp, input int r_on_exp, input int change_k,
                                input logic [7:0] change_g, input logic [BRIGHT_W-1:0] change_b);
        int g_on = 0, g_bad = 0, r_on = 0, r_bad = 0, overlap = 0, fs_early = 0, fs_last = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clock);
            if (led_green != 8'h00) g_on++;
            if (led_green != 8'h00 && led_green != g_exp) g_bad++;
            if (led_red != 8'h00) r_on++;
            if (led_red != 8'h00 && led_red != r_exp) r_bad++;
            if ((led_green & led_red) != 8'h00) overlap++;
            if (frame_start && k < FRAME) fs_early++;
            if (frame_start && k == FRAME) fs_last = 1;
            if (k == change_k) begin
                green_in   = change_g;
                brightness = change_b;
            end
        end
        checkOutput({name, "_green_on"}, g_on, g_on_exp);
        checkOutput({name, "_green_pattern"}, g_bad, 0);
        checkOutput({name, "_red_on"}, r_on, r_on_exp);
        checkOutput({name, "_red_pattern"}, r_bad, 0);
        checkOutput({name, "_overlap"}, overlap, 0);
        checkOutput({name, "_fs_early"}, fs_early, 0);
        checkOutput({name, "_fs_period"}, fs_last, 1);
    endtask

    initial begin
        int bad_fs;
        int bad_led;
        int found;

        vecs[0] = '{8'hFF, 8'h00, 4'd15};
        vecs[1] = '{8'h81, 8'h81, 4'd8};
        vecs[2] = '{8'h00, 8'h3C, 4'd4};
        vecs[3] = '{8'hA5, 8'h5A, 4'd0};
        vecs[4] = '{8'h0F, 8'hF0, 4'd1};
        vecs[5] = '{8'hFF, 8'hFF, 4'd12};

        reset      = 1'b0;
        enable     = 1'b0;
        green_in   = 8'h00;
        red_in     = 8'h00;
        brightness = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_led_green", int'(led_green), 0);
        checkOutput("reset_led_red", int'(led_red), 0);
        checkOutput("reset_frame_start", int'(frame_start), 0);

        reset    = 1'b1;
        green_in = 8'hFF;
        red_in   = 8'hFF;
        brightness = 4'd15;
        bad_fs  = 0;
        bad_led = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (frame_start) bad_fs++;
            if (led_green != 8'h00 || led_red != 8'h00) bad_led++;
        end
        checkOutput("idle_frame_start", bad_fs, 0);
        checkOutput("idle_leds", bad_led, 0);

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].g, vecs[v].r, vecs[v].b);
            waitFrameStart($sformatf("vec%0d_start", v));
            measureFrame($sformatf("vec%0d", v), vecs[v].g, vecs[v].r,
                         (vecs[v].g != 8'h00) ? exp_duty(int'(vecs[v].b)) * PRESCALE : 0,
                         (vecs[v].r != 8'h00) ? exp_duty(int'(vecs[v].b)) * PRESCALE : 0,
                         0, 8'h00, '0);
        end

        // Pattern and brightness change mid-frame must wait for the next frame.
        applyStimulus(8'hFF, 8'h00, 4'd15);
        waitFrameStart("tear_start");
        measureFrame("tear_frame1", 8'hFF, 8'h00, exp_duty(15) * PRESCALE, 0, 10, 8'h0F, 4'd4);
        measureFrame("tear_frame2", 8'h0F, 8'h00, exp_duty(4) * PRESCALE, 0, 0, 8'h00, '0);

        // Enable dropped while the red die is lit.
        applyStimulus(8'hFF, 8'hFF, 4'd15);
        waitFrameStart("drop_start");
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            @(negedge clock);
            if (led_red != 8'h00) found = 1;
        end
        checkOutput("drop_red_active", found, 1);
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        checkOutput("drop_frame_start", int'(frame_start), 0);
        @(negedge clock);
        checkOutput("drop_led_green", int'(led_green), 0);
        checkOutput("drop_led_red", int'(led_red), 0);
        bad_led = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (led_green != 8'h00 || led_red != 8'h00 || frame_start) bad_led++;
        end
        checkOutput("drop_idle_quiet", bad_led, 0);
        enable = 1'b1;
        @(negedge clock);
        checkOutput("reenable_frame_start", int'(frame_start), 1);
        measureFrame("reenable", 8'hFF, 8'hFF, exp_duty(15) * PRESCALE, exp_duty(15) * PRESCALE, 0, 8'hFF, 4'd15);

        // Asynchronous reset between clock edges.
        applyStimulus(8'hFF, 8'h00, 4'd15);
        waitFrameStart("areset_start");
        repeat (4) @(negedge clock);
        checkOutput("areset_pre_green", int'(led_green), 8'hFF);
        #2 reset = 1'b0;
        #1;
        checkOutput("areset_led_green", int'(led_green), 0);
        checkOutput("areset_led_red", int'(led_red), 0);
        checkOutput("areset_frame_start", int'(frame_start), 0);
        @(negedge clock);
        reset = 1'b1;
        waitFrameStart("areset_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
